// File: rtl/median_window_feeder.sv
// Five-deep sliding window of samples feeding the 5-input median sorter.
// Presents each window once under a valid/ready handshake, with backpressure upstream.
module median_window_feeder #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] win0,
    output logic [WIDTH-1:0] win1,
    output logic [WIDTH-1:0] win2,
    output logic [WIDTH-1:0] win3,
    output logic [WIDTH-1:0] win4,
    output logic [2:0]       fill_cnt,
    output logic [1:0]       dbg_state
);

    // Handshake: a sample moves when in_valid & in_ready & ~flush on a rising
    // edge; a window is consumed when out_valid & out_ready & ~flush.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FRESH = 2'd1,
        ST_SPENT = 2'd2
    } state_t;

    localparam logic [2:0] FULL_CNT = 3'd5;

    state_t           state_q, state_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] win_q [5];
    logic [WIDTH-1:0] win_d [5];
    logic             acc;
    logic             cons;

    assign acc  = in_valid & in_ready & ~flush;
    // A window shown during a flush cycle is discarded, not consumed.
    assign cons = out_valid_q & out_ready & ~flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (acc && fill_cnt_q == 3'd4) begin
                        state_d = ST_FRESH;
                    end
                end
                ST_FRESH: begin
                    if (cons && !acc) begin
                        state_d = ST_SPENT;
                    end
                end
                ST_SPENT: begin
                    if (acc) begin
                        state_d = ST_FRESH;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // Output logic: in_ready follows out_ready only while a window is pending.
    always_comb begin
        in_ready = 1'b1;
        if (flush) begin
            in_ready = 1'b0;
        end else if (state_q == ST_FRESH) begin
            in_ready = out_ready;
        end
        out_valid_d = (state_d == ST_FRESH);
    end

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        for (int i = 0; i < 5; i++) begin
            win_d[i] = win_q[i];
        end
        if (flush) begin
            fill_cnt_d = 3'd0;
            for (int i = 0; i < 5; i++) begin
                win_d[i] = '0;
            end
        end else if (acc) begin
            if (fill_cnt_q != FULL_CNT) begin
                fill_cnt_d = fill_cnt_q + 3'd1;
            end
            for (int i = 0; i < 4; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[4] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q  <= 3'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 5; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_cnt_q;
    assign win0      = win_q[0];
    assign win1      = win_q[1];
    assign win2      = win_q[2];
    assign win3      = win_q[3];
    assign win4      = win_q[4];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: directed test-plan steps then random traffic,
// all checked against a queue-style window model.
module tb_median_window_feeder;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] win0, win1, win2, win3, win4;
    logic [2:0]   fill_cnt;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: window contents, sample count, pending-window flag
    int mw [5];
    int mcnt;
    bit mfresh;

    median_window_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .win0      (win0),
        .win1      (win1),
        .win2      (win2),
        .win3      (win3),
        .win4      (win4),
        .fill_cnt  (fill_cnt),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) mw[i] = 0;
        mcnt   = 0;
        mfresh = 0;
    endtask

    function automatic int median5(input int a, input int b, input int c, input int d, input int e);
        int v [5];
        int t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[2];
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".out_valid"}, out_valid, mfresh);
        chk({tag, ".fill_cnt"}, fill_cnt, mcnt);
        chk({tag, ".win0"}, win0, mw[0]);
        chk({tag, ".win1"}, win1, mw[1]);
        chk({tag, ".win2"}, win2, mw[2]);
        chk({tag, ".win3"}, win3, mw[3]);
        chk({tag, ".win4"}, win4, mw[4]);
    endtask

    // One clock: drive after the previous edge, check in_ready mid-cycle,
    // advance the model at the edge, check registers 1 time unit later.
    task automatic cycle(input string tag, input bit f, input bit v, input int d, input bit r);
        bit exp_rdy;
        bit acc;
        bit cons;
        flush     = f;
        in_valid  = v;
        in_data   = d[W-1:0];
        out_ready = r;
        @(negedge clk);
        exp_rdy = !f && (!mfresh || r);
        chk({tag, ".in_ready"}, in_ready, exp_rdy);
        @(posedge clk);
        if (f) begin
            model_clear();
        end else begin
            acc  = v && exp_rdy;
            cons = mfresh && r;
            if (acc) begin
                for (int i = 0; i < 4; i++) mw[i] = mw[i+1];
                mw[4] = d % 64;
                mcnt  = (mcnt < 5) ? mcnt + 1 : 5;
            end
            mfresh = (acc && mcnt == 5) || (mfresh && !cons);
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        int vals [5];
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        #2;
        check_regs("reset");
        chk("reset.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill
        vals[0] = 10; vals[1] = 20; vals[2] = 30; vals[3] = 40; vals[4] = 50;
        for (int i = 0; i < 5; i++) begin
            chk("fill.out_valid_low", out_valid, 0);
            cycle("fill", 0, 1, vals[i], 1);
        end
        chk("fill.valid_up", out_valid, 1);
        chk("fill.cnt5", fill_cnt, 5);
        chk("fill.win0", win0, 10);
        chk("fill.win4", win4, 50);
        chk("fill.median", median5(win0, win1, win2, win3, win4), 30);

        // Streaming
        cycle("stream5", 0, 1, 5, 1);
        chk("stream5.median", median5(win0, win1, win2, win3, win4), 30);
        cycle("stream63", 0, 1, 63, 1);
        chk("stream63.median", median5(win0, win1, win2, win3, win4), 40);
        chk("stream63.win4", win4, 63);

        // Backpressure
        for (int i = 0; i < 3; i++) cycle("bp_hold", 0, 1, 7, 0);
        chk("bp_hold.win4", win4, 63);
        cycle("bp_release", 0, 1, 7, 1);
        chk("bp_release.win4", win4, 7);

        // Spent window
        cycle("spent1", 0, 0, 0, 1);
        chk("spent1.out_valid", out_valid, 0);
        cycle("spent2", 0, 0, 0, 1);
        cycle("spent_refill", 0, 1, 9, 1);
        chk("spent_refill.win4", win4, 9);
        chk("spent_refill.out_valid", out_valid, 1);

        // Flush against a concurrent sample
        cycle("flush", 1, 1, 33, 1);
        chk("flush.cnt", fill_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            chk("postflush.out_valid_low", out_valid, 0);
            cycle("postflush", 0, 1, 11 + i, 1);
        end
        chk("postflush.out_valid", out_valid, 1);

        // Asynchronous reset in the middle of a fill
        cycle("flush2", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("prefill", 0, 1, 40 + i, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_regs("async_rst");
        chk("async_rst.in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs("async_rst_rel");
        for (int i = 0; i < 5; i++) begin
            chk("refill.out_valid_low", out_valid, 0);
            cycle("refill", 0, 1, 50 + i, 1);
        end
        chk("refill.out_valid", out_valid, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 63),
                  ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/median_window_feeder.md
# median_window_feeder

Upstream stage of the 5-input median sorter. Collects a stream of 6-bit samples into a 5-deep sliding window and presents the window on five parallel buses that wire directly to the sorter's `in_num0`..`in_num4`. A valid/ready handshake makes sure each window is presented exactly once, with backpressure to the sample source. After the initial fill, every accepted sample produces one new window.

## Interface
- `WIDTH`, default 6: sample width. It must match the sorter input width.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `flush`  input  1  synchronous clear of the window. Priority over all other inputs.
- `in_valid`  input  1  `in_data` holds a sample.
- `in_data`  input  WIDTH  sample value, unsigned.
- `in_ready`  output  1  block accepts a sample this cycle. Combinational.
- `out_ready`  input  1  downstream consumes the presented window this cycle.
- `out_valid`  output  1  `win0`..`win4` hold a fresh, unconsumed window. Registered.
- `win0`..`win4`  output  WIDTH each  window samples. `win0` is the oldest, `win4` the newest. Registered.
- `fill_cnt`  output  3  number of samples held, 0..5. Registered.

## Operation
- Accept condition: `acc = in_valid & in_ready & ~flush`.
- Consume condition: `cons = out_valid & out_ready`.
- On `acc`, the window shifts: `win0<=win1`, `win1<=win2`, `win2<=win3`, `win3<=win4`, `win4<=in_data`.
- No arithmetic on samples. Values pass through unchanged. `fill_cnt` saturates at 5.
- FSM states:
  - FILL: `fill_cnt` < 5, `out_valid`=0, `in_ready`=1.
    - On `acc`, `fill_cnt` increments.
    - When `acc` brings `fill_cnt` from 4 to 5, go to FRESH.
  - FRESH: window unconsumed, `out_valid`=1, `in_ready`=`out_ready`.
    - `cons` & `acc`: shift and stay in FRESH. The new window is valid next cycle.
    - `cons` & ~`acc`: go to SPENT.
    - ~`cons`: hold all registers. `in_valid` is ignored because `in_ready`=0.
  - SPENT: window already consumed, `out_valid`=0, `in_ready`=1.
    - On `acc`, shift and go to FRESH.
- `flush`, from any state:
  - Next cycle: state FILL, `fill_cnt`=0, all `win*`=0, `out_valid`=0.
  - `in_ready`=0 during the flush cycle.
  - A sample offered with `flush` is dropped.
  - A window presented during the flush cycle is not counted as consumed, even if `out_ready`=1. The downstream must ignore it.
- `out_ready` while `out_valid`=0 has no effect.
- Window content is stable whenever `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (asynchronous, `rst_n`=0) sets:
  - state FILL, `fill_cnt`=0, `win0`..`win4`=0, `out_valid`=0.
  - `in_ready`=1 (it is combinational from state and `flush`).
- Reset released mid-stream: all history is lost and the fill restarts from 0.
- Latency: `out_valid` rises one cycle after the edge that accepts the 5th sample since reset or flush.
- In FRESH, with `in_valid`=1 and `out_ready`=1 every cycle, throughput is one window per cycle.
- `in_ready` depends combinationally on `out_ready` only in FRESH. Otherwise it is a function of state and `flush` only.
- The sorter is combinational, so the median is valid in the same cycle as `out_valid`. The consumer samples it on the edge where `cons`=1.

## Test plan
- **Fill:** after reset, feed 10,20,30,40,50 on consecutive cycles with `out_ready`=1.
  - `out_valid`=0 through the 5th sample edge, then 1 the next cycle.
  - `win0`..`win4`=10,20,30,40,50; sorter median = 30; `fill_cnt`=5.
- **Streaming:** continue with 5, then 63, with `in_valid`=`out_ready`=1.
  - Windows appear on consecutive cycles: 20,30,40,50,5 (median 30), then 30,40,50,5,63 (median 40).
  - `out_valid` stays 1.
- **Backpressure:** in FRESH, hold `out_ready`=0 for 3 cycles with `in_valid`=1, `in_data`=7.
  - `in_ready`=0, window and `out_valid` unchanged.
  - When `out_ready` returns to 1, 7 is accepted that cycle and the next window ends in 7.
- **Spent window:** `out_ready`=1, `in_valid`=0 for 2 cycles.
  - `out_valid` falls after one consume and stays 0 (SPENT).
  - Next sample 9 gives `out_valid`=1 with `win4`=9 the following cycle.
- **Flush vs accept:** in FRESH, assert `flush` together with `in_valid`=1, `in_data`=33.
  - `in_ready`=0, sample dropped.
  - Next cycle: `fill_cnt`=0, `out_valid`=0, all `win*`=0.
  - Five further samples are needed before `out_valid` rises again.
- **Async reset mid-fill:** pulse `rst_n` low between clock edges after 3 samples.
  - Outputs clear immediately without a clock edge.
  - After release, five new samples are needed for `out_valid`.
